// File: rtl/index_pkg.sv
// Shared types and constants for the BRAM index packer/unpacker pair.
// Lane k of a packed word occupies bits [k*IDX_W +: IDX_W].
package index_pkg;

  localparam int IDX_W  = 16;
  localparam int LANES  = 4;
  localparam int WORD_W = IDX_W * LANES;
  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [IDX_W-1:0] PAD_IDX = 16'hFFFF;

  typedef logic [IDX_W-1:0] index_t;

  // Packed lane view of one memory word; [k] selects lane k.
  typedef logic [LANES-1:0][IDX_W-1:0] word_t;

  typedef enum logic {FILL, HOLD} pack_state_t;

  // Word with every lane holding the pad index.
  function automatic word_t pad_word();
    word_t w;
    for (int k = 0; k < LANES; k++) w[k] = PAD_IDX;
    return w;
  endfunction

endpackage

// File: rtl/index_packer_if.sv
// Stream interface of the index packer: index stream in, packed words out.
// The out_par lane-parity signal exists only when INDEX_PACKER_PARITY_EN
// is defined.
interface index_packer_if;
  import index_pkg::*;

  logic          in_valid;
  logic          in_ready;
  index_t        in_index;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [WORD_W-1:0] out_word;
  logic [2:0]    out_count;
  logic          out_last;
`ifdef INDEX_PACKER_PARITY_EN
  logic [LANES-1:0] out_par;

  // Producer of indices and consumer of words.
  modport master (
    output in_valid, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_count, out_last, out_par
  );

  // The packer itself.
  modport slave (
    input  in_valid, in_index, in_last, out_ready,
    output in_ready, out_valid, out_word, out_count, out_last, out_par
  );
`else
  // Producer of indices and consumer of words.
  modport master (
    output in_valid, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_count, out_last
  );

  // The packer itself.
  modport slave (
    input  in_valid, in_index, in_last, out_ready,
    output in_ready, out_valid, out_word, out_count, out_last
  );
`endif

endinterface

// File: rtl/index_packer.sv
// index_packer: gathers 16-bit column indices into 64-bit words, four lanes
// per word, lane 0 in the LSBs. A row end flushes a partial word padded with
// PAD_IDX. Optional per-lane even parity on out_par is enabled by defining
// INDEX_PACKER_PARITY_EN.
module index_packer
  import index_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  index_packer_if.slave  bus
);

  pack_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            lane_q, lane_d;
  word_t            word_q, word_d;
  logic [2:0]       count_q, count_d;
  logic             last_q, last_d;
  logic             in_fire, out_fire;

  // Lanes below cnt come from the bank, lane cnt is the incoming index,
  // lanes above are padding.
  function automatic word_t build_word(word_t bank, logic [CNT_W-1:0] cnt,
                                       index_t idx);
    word_t w;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(cnt))       w[k] = bank[k];
      else if (k == int'(cnt)) w[k] = idx;
      else                     w[k] = PAD_IDX;
    end
    return w;
  endfunction

  // Backpressure only while a word is pending; no path from in_valid.
  assign bus.in_ready  = (state_q == FILL) || bus.out_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_word  = word_q;
  assign bus.out_count = count_q;
  assign bus.out_last  = last_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = (state_q == HOLD) && bus.out_ready;

  // Next-state logic for the FSM, lane pointer, lane bank and output word.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    word_d  = word_q;
    count_d = count_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          lane_d[cnt_q] = bus.in_index;
          if (cnt_q == CNT_W'(LANES - 1) || bus.in_last) begin
            state_d = HOLD;
            word_d  = build_word(lane_q, cnt_q, bus.in_index);
            count_d = 3'(cnt_q) + 3'd1;
            last_d  = bus.in_last;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_fire) begin
          lane_d = pad_word();
          if (in_fire) begin
            lane_d[0] = bus.in_index;
            if (bus.in_last || LANES == 1) begin
              // Back-to-back single-lane word: stay in HOLD with it loaded.
              word_d  = build_word(lane_q, '0, bus.in_index);
              count_d = 3'd1;
              last_d  = bus.in_last;
              cnt_d   = '0;
            end else begin
              state_d = FILL;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            state_d = FILL;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, pointer, lane bank and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      // NOTE: the lane bank is reset on purpose: reset discards partial
      // lanes and the idle out_word must read as all PAD_IDX.
      lane_q  <= pad_word();
      word_q  <= pad_word();
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

`ifdef INDEX_PACKER_PARITY_EN
  logic [LANES-1:0] par_q, par_d;

  // Parity follows the next word, so it is loaded and held with out_word.
  always_comb begin
    par_d = '0;
    for (int k = 0; k < LANES; k++) par_d[k] = ^word_d[k];
  end

  // Parity register, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= '0;
    else        par_q <= par_d;
  end

  assign bus.out_par = par_q;
`endif

endmodule

// File: tb/tb_index_packer.sv
// Directed self-checking bench for index_packer. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
module tb_index_packer;
  import index_pkg::*;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  index_packer_if bus ();

  index_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Offer one index for one cycle.
  task automatic push(input logic [15:0] idx, input logic last);
    bus.in_valid = 1'b1;
    bus.in_index = idx;
    bus.in_last  = last;
    step();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_index  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_word",  bus.out_word, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    check("rst_out_last",  64'(bus.out_last), 64'd0);
`ifdef INDEX_PACKER_PARITY_EN
    check("rst_out_par",   64'(bus.out_par), 64'd0);
`endif
    rst_n = 1'b1;
    step();
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);

    // Full word 1..4
    for (int i = 1; i <= 4; i++) push(16'(i), 1'b0);
    idle();
    check("w4_valid", 64'(bus.out_valid), 64'd1);
    check("w4_word",  bus.out_word, 64'h0004_0003_0002_0001);
    check("w4_count", 64'(bus.out_count), 64'd4);
    check("w4_last",  64'(bus.out_last), 64'd0);
    step();
    check("w4_drained", 64'(bus.out_valid), 64'd0);

    // Partial word flushed by in_last
    push(16'h00AA, 1'b0);
    push(16'h00BB, 1'b1);
    idle();
    check("p2_word",  bus.out_word, 64'hFFFF_FFFF_00BB_00AA);
    check("p2_count", 64'(bus.out_count), 64'd2);
    check("p2_last",  64'(bus.out_last), 64'd1);
    step();

    // Eight back-to-back indices: no bubble, two words
    for (int i = 1; i <= 8; i++) begin
      check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      push(16'h0100 + 16'(i), 1'b0);
      if (i == 4) begin
        check("b2b_w0", bus.out_word, 64'h0104_0103_0102_0101);
        check("b2b_w0_valid", 64'(bus.out_valid), 64'd1);
      end
    end
    idle();
    check("b2b_w1", bus.out_word, 64'h0108_0107_0106_0105);
    check("b2b_w1_count", 64'(bus.out_count), 64'd4);
    step();

    // Backpressure with a full word pending
    for (int i = 1; i <= 4; i++) push(16'h0030 + 16'(i), 1'b0);
    idle();
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_word", bus.out_word, 64'h0034_0033_0032_0031);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    push(16'h0010, 1'b1);
    idle();
    check("bp_next_valid", 64'(bus.out_valid), 64'd1);
    check("bp_next_word",  bus.out_word, 64'hFFFF_FFFF_FFFF_0010);
    check("bp_next_count", 64'(bus.out_count), 64'd1);
    check("bp_next_last",  64'(bus.out_last), 64'd1);
    step();
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // in_last with no partial data gives a single-lane word
    push(16'h0055, 1'b1);
    idle();
    check("solo_word",  bus.out_word, 64'hFFFF_FFFF_FFFF_0055);
    check("solo_count", 64'(bus.out_count), 64'd1);
    step();

    // Reset mid-word discards the partial lanes
    push(16'h0041, 1'b0);
    push(16'h0042, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_word",  bus.out_word, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) push(16'h0020 + 16'(i), 1'b0);
    idle();
    check("midrst_new_word",  bus.out_word, 64'h0024_0023_0022_0021);
    check("midrst_new_count", 64'(bus.out_count), 64'd4);
    step();

`ifdef INDEX_PACKER_PARITY_EN
    // Lane weights 0,1,2,3 ones -> bits 0..3 parity 0,1,0,1
    push(16'h0000, 1'b0);
    push(16'h0001, 1'b0);
    push(16'h0003, 1'b0);
    push(16'h0007, 1'b0);
    idle();
    check("par_word", bus.out_word, 64'h0007_0003_0001_0000);
    check("par_bits", 64'(bus.out_par), 64'b1010);
    step();
    // 0x00AB has five ones; pad lanes 0xFFFF have even weight
    push(16'h00AB, 1'b1);
    idle();
    check("par_pad", 64'(bus.out_par), 64'b0001);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
